wb_burst_fill: RTL



---
 rtl/wb_burst_fill_if.sv | 27 ++
 rtl/wb_burst_fill.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/wb_burst_fill_if.sv
// Wishbone B3 master/slave bundle used between wb_burst_fill and the burst RAM.
interface wb_burst_fill_if #(
    parameter int aw = 23
);
    logic [aw-1:0] wb_adr_o;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_burst_fill.sv
// Wishbone burst master: critical-word-first wrapping line fill or single classic write,
// with per-beat timeout and clean cycle termination on ack, err/rty or timeout.
//
//   state    | meaning
//   st_idle  | ready for a client request, bus idle
//   st_fill  | wrapping read burst in progress, words streamed to client
//   st_write | single classic write in progress
//   st_end   | one-cycle bus gap, done_o (and err_o) reported
module wb_burst_fill #(
    parameter int aw        = 23,
    parameter int dw        = 32,
    parameter int burst_len = 8,
    parameter int timeout   = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [aw-1:0] req_adr_i,
    input  logic [dw-1:0] req_dat_i,
    input  logic [3:0]    req_sel_i,
    output logic          rd_valid_o,
    output logic [dw-1:0] rd_dat_o,
    output logic [3:0]    rd_idx_o,
    output logic          rd_last_o,
    output logic          done_o,
    output logic          err_o,
    wb_burst_fill_if.master wb
);
    localparam int iw = $clog2(burst_len);
    localparam logic [iw-1:0] last_beat = iw'(burst_len - 1);
    localparam logic [7:0]    tmo_last  = 8'(timeout - 1);
    localparam logic [1:0]    bte_burst = (burst_len == 4)  ? 2'b01 :
                                          (burst_len == 16) ? 2'b11 : 2'b10;

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_fill  = 2'd1;
    localparam logic [1:0] st_write = 2'd2;
    localparam logic [1:0] st_end   = 2'd3;

    logic [1:0]       state_q;
    logic [aw-1:iw+2] adr_hi_q;
    logic [iw-1:0]    idx_q;
    logic [dw-1:0]    dat_q;
    logic [3:0]       sel_q;
    logic [iw-1:0]    beat_q;
    logic [7:0]       tmo_q;
    logic             err_q;
    logic             rd_valid_q;
    logic [dw-1:0]    rd_dat_q;
    logic [iw-1:0]    rd_idx_q;
    logic             rd_last_q;

    logic in_fill;
    logic in_write;
    logic bus_err;
    logic tmo_hit;
    logic unused_adr_lsb;

    assign in_fill        = (state_q == st_fill);
    assign in_write       = (state_q == st_write);
    assign bus_err        = wb.wb_err_i | wb.wb_rty_i;
    assign tmo_hit        = (tmo_q == tmo_last);
    assign unused_adr_lsb = ^req_adr_i[1:0];

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= st_idle;
            adr_hi_q   <= '0;
            idx_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_dat_q   <= '0;
            rd_idx_q   <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            case (state_q)
                st_idle: begin
                    if (req_valid_i) begin
                        adr_hi_q <= req_adr_i[aw-1:iw+2];
                        idx_q    <= req_adr_i[iw+1:2];
                        dat_q    <= req_dat_i;
                        sel_q    <= req_sel_i;
                        beat_q   <= '0;
                        tmo_q    <= '0;
                        err_q    <= 1'b0;
                        state_q  <= req_we_i ? st_write : st_fill;
                    end
                end
                st_fill: begin
                    // err/rty takes priority over a simultaneous ack; that beat is dropped
                    if (bus_err) begin
                        err_q   <= 1'b1;
                        state_q <= st_end;
                    end else if (wb.wb_ack_i) begin
                        rd_valid_q <= 1'b1;
                        rd_dat_q   <= wb.wb_dat_i;
                        rd_idx_q   <= idx_q;
                        rd_last_q  <= (beat_q == last_beat);
                        idx_q      <= idx_q + 1'b1;
                        beat_q     <= beat_q + 1'b1;
                        tmo_q      <= '0;
                        if (beat_q == last_beat) state_q <= st_end;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        state_q <= st_end;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                st_write: begin
                    if (bus_err || (!wb.wb_ack_i && tmo_hit)) begin
                        err_q   <= 1'b1;
                        state_q <= st_end;
                    end else if (wb.wb_ack_i) begin
                        state_q <= st_end;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= st_idle;
            endcase
        end
    end

    // Gated by reset so the client sees no ready while the block is held in reset
    assign req_ready_o = (state_q == st_idle) & wb_rst_i;
    assign rd_valid_o  = rd_valid_q;
    assign rd_dat_o    = rd_dat_q;
    assign rd_idx_o    = 4'(rd_idx_q);
    assign rd_last_o   = rd_last_q;
    assign done_o      = (state_q == st_end);
    assign err_o       = (state_q == st_end) & err_q;

    assign wb.wb_cyc_o = in_fill | in_write;
    assign wb.wb_stb_o = in_fill | in_write;
    assign wb.wb_we_o  = in_write;
    assign wb.wb_adr_o = {adr_hi_q, idx_q, 2'b00};
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = in_fill ? 4'hf : (in_write ? sel_q : 4'h0);
    assign wb.wb_cti_o = in_fill ? ((beat_q == last_beat) ? 3'b111 : 3'b010) : 3'b000;
    assign wb.wb_bte_o = in_fill ? bte_burst : 2'b00;
endmodule
